// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the data-side load/store path: store sizes, load formats,
// MMIO register offsets and STATUS bit positions.
package dmem_lsu_pkg;

   typedef enum logic [1:0] {
      MW_NONE = 2'b00,
      MW_SB   = 2'b01,
      MW_SH   = 2'b10,
      MW_SW   = 2'b11
   } mem_write_e;

   // funct3 load encodings; anything else is treated as LW
   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b100;
   localparam logic [2:0] LD_LHU = 3'b101;

   localparam logic [3:0] OFF_GPIO       = 4'h0;
   localparam logic [3:0] OFF_CYCLE      = 4'h4;
   localparam logic [3:0] OFF_STATUS     = 4'h8;
   localparam logic [3:0] OFF_FAULT_ADDR = 4'hC;

   localparam int ST_MISALIGN = 0;
   localparam int ST_UNMAPPED = 1;

endpackage

// File: rtl/dmem_lsu_ram.sv
// Word-organised data RAM with per-byte write enables, synchronous write and
// asynchronous read. Contents are deliberately not cleared by reset.
module dmem_lsu_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic [AW-1:0] addr_i,
   input  logic [3:0]    we_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit for the single-cycle core: address decode, store lane steering,
// load extension, and the GPIO / CYCLE / STATUS / FAULT_ADDR register window.
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int          DEPTH     = 1024,
   parameter logic [31:0] MMIO_BASE = 32'h0001_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [1:0]  mem_write,
   input  logic [2:0]  size_load,
   output logic [31:0] rdata,
   output logic [31:0] gpio_out,
   output logic        fault
);

   localparam int          AW        = $clog2(DEPTH);
   localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

   logic        is_ram, is_mmio;
   logic [31:0] ram_word, ram_shift, ram_load, mmio_rd;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic        st_mis, st_unmapped, st_fault, mmio_wr;
   logic [3:0]  ram_we;
   logic [31:0] ram_wdata;

   logic [31:0] gpio_q, gpio_d;
   logic [31:0] cycle_q, cycle_d;
   logic [1:0]  status_q, status_d;
   logic [31:0] fault_addr_q, fault_addr_d;

   assign is_ram  = addr < RAM_BYTES;
   assign is_mmio = addr[31:4] == MMIO_BASE[31:4];

   dmem_lsu_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk     (clk),
      .addr_i  (addr[AW+1:2]),
      .we_i    (ram_we),
      .wdata_i (ram_wdata),
      .rdata_o (ram_word)
   );

   always_comb begin
      ram_shift = ram_word >> {addr[1:0], 3'b000};
      ld_byte   = ram_shift[7:0];
      ld_half   = addr[1] ? ram_word[31:16] : ram_word[15:0];
      ram_load  = '0;
      case (size_load)
         LD_LB:   ram_load = {{24{ld_byte[7]}}, ld_byte};
         LD_LBU:  ram_load = {24'h0, ld_byte};
         LD_LH:   if (!addr[0]) ram_load = {{16{ld_half[15]}}, ld_half};
         LD_LHU:  if (!addr[0]) ram_load = {16'h0, ld_half};
         default: if (addr[1:0] == 2'b00) ram_load = ram_word;
      endcase
   end

   // MMIO reads ignore size_load and return the whole register
   always_comb begin
      mmio_rd = '0;
      case (addr[3:0])
         OFF_GPIO:       mmio_rd = gpio_q;
         OFF_CYCLE:      mmio_rd = cycle_q;
         OFF_STATUS:     mmio_rd = {30'h0, status_q};
         OFF_FAULT_ADDR: mmio_rd = fault_addr_q;
         default:        mmio_rd = '0;
      endcase
   end

   assign rdata = is_ram ? ram_load : (is_mmio ? mmio_rd : 32'h0);

   always_comb begin
      st_mis = 1'b0;
      case (mem_write)
         MW_SH:   st_mis = addr[0];
         MW_SW:   st_mis = addr[1:0] != 2'b00;
         default: st_mis = 1'b0;
      endcase
   end

   assign st_unmapped = (mem_write != MW_NONE) && !is_ram && !is_mmio;
   assign st_fault    = st_mis || st_unmapped;

   always_comb begin
      ram_we    = 4'b0000;
      ram_wdata = wdata;
      if (is_ram && !st_fault && !reset) begin
         case (mem_write)
            MW_SB: begin
               ram_we    = 4'b0001 << addr[1:0];
               ram_wdata = {4{wdata[7:0]}};
            end
            MW_SH: begin
               ram_we    = addr[1] ? 4'b1100 : 4'b0011;
               ram_wdata = {2{wdata[15:0]}};
            end
            MW_SW:   ram_we = 4'b1111;
            default: ram_we = 4'b0000;
         endcase
      end
   end

   // Only aligned word stores reach the registers; narrower MMIO stores are dropped
   assign mmio_wr = is_mmio && (mem_write == MW_SW) && !st_fault;

   always_comb begin
      gpio_d       = gpio_q;
      cycle_d      = cycle_q + 32'd1;
      status_d     = status_q;
      fault_addr_d = fault_addr_q;
      if (mmio_wr) begin
         case (addr[3:0])
            OFF_GPIO:   gpio_d   = wdata;
            OFF_STATUS: status_d = status_q & ~wdata[1:0];
            default:    ;
         endcase
      end
      if (st_mis)      status_d[ST_MISALIGN] = 1'b1;
      if (st_unmapped) status_d[ST_UNMAPPED] = 1'b1;
      if (st_fault)    fault_addr_d = addr;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gpio_q       <= '0;
         cycle_q      <= '0;
         status_q     <= '0;
         fault_addr_q <= '0;
      end else begin
         gpio_q       <= gpio_d;
         cycle_q      <= cycle_d;
         status_q     <= status_d;
         fault_addr_q <= fault_addr_d;
      end
   end

   assign gpio_out = gpio_q;
   assign fault    = |status_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: expected values go into a scoreboard queue as each
// step is driven and are popped when the DUT output is sampled mid-low-phase.
module tb_dmem_lsu;

   localparam logic [31:0] MB       = 32'h0001_0000;
   localparam logic [31:0] A_GPIO   = MB + 32'h0;
   localparam logic [31:0] A_CYCLE  = MB + 32'h4;
   localparam logic [31:0] A_STATUS = MB + 32'h8;
   localparam logic [31:0] A_FADDR  = MB + 32'hC;

   localparam logic [1:0] SB = 2'b01, SH = 2'b10, SW = 2'b11;
   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [1:0]  mem_write = 2'b00;
   logic [2:0]  size_load = LW;
   logic [31:0] rdata, gpio_out;
   logic        fault;

   int total = 0;
   int bad   = 0;
   logic [31:0] sb_q [$];
   logic [31:0] cyc_model = '0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) cyc_model <= '0;
      else       cyc_model <= cyc_model + 32'd1;
   end

   dmem_lsu #(.DEPTH(1024), .MMIO_BASE(MB)) dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .wdata     (wdata),
      .mem_write (mem_write),
      .size_load (size_load),
      .rdata     (rdata),
      .gpio_out  (gpio_out),
      .fault     (fault)
   );

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] exp;
      exp = sb_q.size() > 0 ? sb_q.pop_front() : 32'hxxxx_xxxx;
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      sb_q.push_back(exp);
      chk(tag, obs);
   endtask

   // Drive a load in the current low phase and compare rdata 2 time units later.
   task automatic load(input string tag, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] exp);
      addr      = a;
      size_load = sz;
      mem_write = 2'b00;
      sb_q.push_back(exp);
      #2;
      chk(tag, rdata);
   endtask

   // Present a store for one rising edge; returns at the following falling edge.
   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] mw);
      @(negedge clk);
      addr      = a;
      wdata     = d;
      mem_write = mw;
      @(negedge clk);
      mem_write = 2'b00;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      reset = 1'b0;
      expect_now("rst_gpio", gpio_out, 32'h0);
      expect_now("rst_fault", {31'h0, fault}, 32'h0);
      load("rst_cycle", A_CYCLE, LW, 32'h0);
      load("rst_status", A_STATUS, LW, 32'h0);

      store(32'h10, 32'hDEAD_BEEF, SW);
      load("lw_10", 32'h10, LW, 32'hDEAD_BEEF);
      load("lb_13", 32'h13, LB, 32'hFFFF_FFDE);
      load("lbu_13", 32'h13, LBU, 32'h0000_00DE);
      load("lh_12", 32'h12, LH, 32'hFFFF_DEAD);
      load("lhu_10", 32'h10, LHU, 32'h0000_BEEF);
      load("lb_10", 32'h10, LB, 32'hFFFF_FFEF);
      load("lh_mis", 32'h11, LH, 32'h0);
      load("lw_mis", 32'h12, LW, 32'h0);

      store(32'h11, 32'h0000_0011, SB);
      load("sb_11", 32'h10, LW, 32'hDEAD_11EF);
      store(32'h12, 32'h0000_2233, SH);
      load("sh_12", 32'h10, LW, 32'h2233_11EF);

      store(32'h20, 32'hCAFE_F00D, SW);
      store(32'h22, 32'h1234_5678, SW);
      load("mis_ram", 32'h20, LW, 32'hCAFE_F00D);
      load("mis_status", A_STATUS, LW, 32'h1);
      load("mis_faddr", A_FADDR, LW, 32'h22);
      expect_now("mis_fault", {31'h0, fault}, 32'h1);
      store(A_STATUS, 32'h1, SW);
      expect_now("w1c_fault", {31'h0, fault}, 32'h0);
      load("w1c_status", A_STATUS, LW, 32'h0);

      store(32'h8000, 32'h0BAD_0BAD, SW);
      load("unm_status", A_STATUS, LW, 32'h2);
      load("unm_faddr", A_FADDR, LW, 32'h8000);
      load("unm_load", 32'h8000, LW, 32'h0);
      load("unm_status2", A_STATUS, LW, 32'h2);
      store(A_STATUS, 32'h2, SW);
      expect_now("unm_clr", {31'h0, fault}, 32'h0);

      store(A_GPIO, 32'hA5, SW);
      expect_now("gpio_sw", gpio_out, 32'hA5);
      load("gpio_rd", A_GPIO, LB, 32'hA5);
      store(A_GPIO, 32'hFF, SB);
      expect_now("gpio_sb", gpio_out, 32'hA5);
      expect_now("gpio_sb_fault", {31'h0, fault}, 32'h0);

      @(negedge clk);
      load("cycle_a", A_CYCLE, LW, cyc_model);
      repeat (7) @(negedge clk);
      load("cycle_b", A_CYCLE, LW, cyc_model);
      store(A_CYCLE, 32'h0, SW);
      load("cycle_wr", A_CYCLE, LW, cyc_model);

      @(negedge clk);
      force dut.cycle_q = 32'hFFFF_FFFF;
      #1;
      release dut.cycle_q;
      load("cycle_max", A_CYCLE, LW, 32'hFFFF_FFFF);
      @(negedge clk);
      load("cycle_wrap", A_CYCLE, LW, 32'h0);

      store(32'h8004, 32'h0, SW);
      expect_now("pre_rst_fault", {31'h0, fault}, 32'h1);
      @(negedge clk);
      addr      = A_GPIO;
      wdata     = 32'h55;
      mem_write = SW;
      reset     = 1'b1;
      @(negedge clk);
      mem_write = 2'b00;
      reset     = 1'b0;
      expect_now("rst2_gpio", gpio_out, 32'h0);
      expect_now("rst2_fault", {31'h0, fault}, 32'h0);
      load("rst2_cycle", A_CYCLE, LW, 32'h0);
      load("rst2_status", A_STATUS, LW, 32'h0);
      load("rst2_faddr", A_FADDR, LW, 32'h0);
      load("rst2_ram10", 32'h10, LW, 32'h2233_11EF);
      load("rst2_ram20", 32'h20, LW, 32'hCAFE_F00D);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog expired observed=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
